midi_transmitter: RTL
=====================

Name: midi_transmitter

Overview:
- Serialises MIDI bytes into a 31250-baud, 8N1 UART stream on `dout`.
- Mirror of the receive path: the host pushes bytes into an internal FIFO with `wr_en`/`full`, and a bit-timing FSM shifts them out LSB first.
- Sits between the synth control logic and the MIDI OUT pin driver.

Parameters:
- CLKS_PER_BIT, 3200, clk cycles per serial bit (100 MHz / 31250 baud); must be >= 2.
- FIFO_DEPTH, 16, entries in the transmit FIFO; must be a power of 2 and >= 2.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- din  in  8  byte to transmit
- wr_en  in  1  push `din` into the FIFO this cycle
- full  out  1  FIFO holds FIFO_DEPTH entries; writes are ignored while high
- dout  out  1  serial MIDI line, idle high, registered output
- busy  out  1  high while a frame is being shifted or the FIFO is non-empty

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset (takes effect at the next clk edge, including mid-frame):
  - `dout`=1, `full`=0, `busy`=0.
  - FIFO is emptied, the FSM returns to IDLE, and the bit and cycle counters clear.
  - A partially sent frame is abandoned; the line goes straight to 1.
- FIFO:
  - A write is accepted when `wr_en`=1 and `full`=0.
  - `wr_en` while `full`=1 is dropped, with no side effects.
  - Write and pop in the same cycle leave the occupancy unchanged.
  - `full` is registered and valid the cycle after the write that filled the FIFO.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `dout`=1. If the FIFO is non-empty, pop the head into the shift register, go to START, and clear the cycle counter.
  - START: `dout`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `dout`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. Go to STOP after bit index 7.
  - STOP: `dout`=1 for CLKS_PER_BIT cycles.
    - In the final STOP cycle, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames.
    - Otherwise go to IDLE.
- Latency:
  - From an idle state, a byte written at edge N is popped at edge N+1.
  - `dout` falls (start bit) at edge N+2.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles.
- `busy` = (state != IDLE) OR FIFO non-empty, registered. It falls the cycle after the last STOP cycle when nothing is queued.
- `din` is sampled only on an accepted write. Later changes to `din` do not affect queued bytes.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined: running-status compression, applied at FIFO pop.
  - The block keeps a last_status register (reset 0x00 = none).
  - A popped byte in 0x80–0xEF equal to last_status is discarded without transmitting. The FSM pops the next entry in the following cycle, or returns to IDLE if the FIFO is empty.
  - A popped byte in 0x80–0xEF different from last_status is transmitted and stored in last_status.
  - Bytes 0xF0–0xF7 are transmitted and clear last_status to 0x00.
  - Bytes 0xF8–0xFF (realtime) are transmitted and leave last_status unchanged.
  - Data bytes 0x00–0x7F are always transmitted.
- Undefined: every accepted byte is transmitted verbatim. No last_status register is built.

Test Plan:
1. CLKS_PER_BIT=4, reset, then write 0x90:
   - `dout` low 2 cycles after the write and held for 4 cycles.
   - Bits 0,0,0,0,1,0,0,1 at 4 cycles each, then high for 4 cycles.
   - `busy` spans 41 cycles.
2. Write 0x90,0x3C,0x64 back-to-back:
   - Three contiguous 40-cycle frames with no idle cycles between stop and start.
   - The decoded stream equals the input order.
3. FIFO_DEPTH=4, CLKS_PER_BIT=4, write 6 bytes 0x01–0x06 on consecutive cycles:
   - 0x01 is popped one cycle after its write; `full` is asserted after the write of 0x05.
   - 0x06 is dropped; exactly 0x01–0x05 are serialised.
4. Assert `reset` for one cycle in the middle of DATA of byte 0xA5:
   - Next cycle `dout`=1, `busy`=0, `full`=0.
   - A subsequent write of 0x7F transmits cleanly.
5. With MIDI_RUNNING_STATUS_EN, write 0x90,0x3C,0x64,0x90,0x40,0x64,0xF8,0x90,0x43,0xF2,0x90:
   - Line carries 0x90,0x3C,0x64,0x40,0x64,0xF8,0x43,0xF2,0x90.
   - Without the macro, all 11 bytes are sent.
6. Write while idle and simultaneously with the final STOP cycle of a running frame:
   - The byte is accepted, and `full`/occupancy stays consistent (simultaneous push/pop).

Source files
------------

// File: rtl/midi_transmitter.sv
// midi_transmitter: 31250-baud 8N1 MIDI serialiser fed by a transmit FIFO.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel status bytes at pop.
module midi_transmitter #(
    parameter int CLKS_PER_BIT = 3200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       dout,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic [1:0]    state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          pop_slot;
    logic          skip;

    assign head     = mem[rd_ptr];
    assign push     = wr_en && !full;
    assign bit_end  = (tick == T_LAST);
    assign pop_slot = (state == IDLE) || ((state == STOP) && bit_end);
    assign pop      = pop_slot && (count != '0);

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       is_chan;
    logic       is_sys;

    assign is_chan = (head >= 8'h80) && (head <= 8'hEF);
    assign is_sys  = (head[7:3] == 5'b11110);
    assign skip    = is_chan && (head == last_status);

    // Track the last transmitted channel status byte
    always_ff @(posedge clk) begin
        if (reset) begin
            last_status <= 8'h00;
        end else if (pop && !skip) begin
            if (is_chan) begin
                last_status <= head;
            end else if (is_sys) begin
                last_status <= 8'h00;
            end
        end
    end
`else
    assign skip = 1'b0;
`endif

    // Occupancy after this cycle's push and pop
    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + 1'b1;
        end else if (pop && !push) begin
            count_nx = count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset since count guards reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nx;
            full  <= (count_nx == DEPTH_C);
        end
    end

    // Bit-timing FSM: a pop restarts the frame, otherwise step through bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (pop) begin
            tick    <= '0;
            bit_idx <= '0;
            shift   <= head;
            state   <= skip ? IDLE : START;
        end else begin
            case (state)
                START: begin
                    if (bit_end) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tick  <= '0;
                        state <= IDLE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    tick <= '0;
                end
            endcase
        end
    end

    // Registered line driver and activity flag
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 1'b1;
            busy <= 1'b0;
        end else begin
            dout <= (state == START) ? 1'b0 :
                    (state == DATA)  ? shift[0] : 1'b1;
            busy <= (state != IDLE) || (count != '0);
        end
    end

endmodule
